shrimp_mem_arbiter: RTL and testbench



---
 rtl/shrimp_mem_pkg.sv | 7 +
 rtl/shrimp_mem_arbiter_if.sv | 34 +++
 rtl/shrimp_mem_starve_cnt.sv | 19 +
 rtl/shrimp_mem_arbiter.sv | 71 +++++++
 tb/tb_shrimp_mem_arbiter.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/shrimp_mem_pkg.sv
// shrimp_mem_pkg: shared widths and enums for the shrimp memfile arbiter
package shrimp_mem_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    typedef enum logic {CLEAR, RUN} state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} gnt_e;
endpackage

// File: rtl/shrimp_mem_arbiter_if.sv
// shrimp_mem_arbiter_if: fetch, data and memfile signals of the shrimp memory arbiter
interface shrimp_mem_arbiter_if
    import shrimp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              if_req_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic              if_req_ready;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              d_req_valid;
    logic              d_req_write;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_req_ready;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_write_val;
    logic              mem_write_enable;
    logic [DATA_W-1:0] mem_read_val;
    modport slave (
        input  if_req_valid, if_req_addr, d_req_valid, d_req_write, d_req_addr, d_req_wdata, mem_read_val,
        output if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
               mem_addr, mem_write_val, mem_write_enable
    );
    modport master (
        output if_req_valid, if_req_addr, d_req_valid, d_req_write, d_req_addr, d_req_wdata, mem_read_val,
        input  if_req_ready, if_resp_valid, if_resp_data, d_req_ready, d_resp_valid, d_resp_data,
               mem_addr, mem_write_val, mem_write_enable
    );
endinterface

// File: rtl/shrimp_mem_starve_cnt.sv
// shrimp_mem_starve_cnt: saturating count of consecutive cycles fetch was denied
module shrimp_mem_starve_cnt #(
    parameter int MAX_WAIT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);
    localparam int W = $clog2(MAX_WAIT + 1);
    localparam logic [W-1:0] MAX = W'(MAX_WAIT);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign at_max_o = cnt_q == MAX;
endmodule

// File: rtl/shrimp_mem_arbiter.sv
// shrimp_mem_arbiter: single-port memfile shared by fetch and data, data priority with
// bounded fetch starvation and an optional zero-fill sweep after reset
module shrimp_mem_arbiter
    import shrimp_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int MAX_WAIT       = 3,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    shrimp_mem_arbiter_if.slave bus,
    output logic init_done_o
);
    localparam state_e RST_ST = CLEAR_ON_RESET ? CLEAR : RUN;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              if_rv_q, if_rv_d, d_rv_q, d_rv_d;
    logic [DATA_W-1:0] if_rd_q, if_rd_d, d_rd_q, d_rd_d;
    logic              at_max, fetch_denied, store;
    gnt_e              gnt;
    assign gnt = state_q != RUN ? GNT_NONE :
                 (bus.if_req_valid && (!bus.d_req_valid || at_max)) ? GNT_IF :
                 bus.d_req_valid ? GNT_D : GNT_NONE;
    assign store        = gnt == GNT_D && bus.d_req_write;
    assign fetch_denied = bus.if_req_valid && gnt != GNT_IF;
    shrimp_mem_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .inc_i    (fetch_denied),
        .clr_i    (!fetch_denied),
        .at_max_o (at_max)
    );
    assign bus.if_req_ready     = gnt == GNT_IF;
    assign bus.d_req_ready      = gnt == GNT_D;
    assign bus.mem_addr         = state_q == CLEAR ? clr_cnt_q :
                                  gnt == GNT_IF ? bus.if_req_addr :
                                  gnt == GNT_D ? bus.d_req_addr : '0;
    assign bus.mem_write_val    = store ? bus.d_req_wdata : '0;
    assign bus.mem_write_enable = state_q == CLEAR || store;
    assign bus.if_resp_valid    = if_rv_q;
    assign bus.if_resp_data     = if_rd_q;
    assign bus.d_resp_valid     = d_rv_q;
    assign bus.d_resp_data      = d_rd_q;
    assign init_done_o          = state_q == RUN;
    always_comb begin
        state_d   = (state_q == CLEAR && clr_cnt_q == '1) ? RUN : state_q;
        clr_cnt_d = state_q == CLEAR ? clr_cnt_q + 1'b1 : '0;
        if_rv_d   = gnt == GNT_IF;
        if_rd_d   = gnt == GNT_IF ? bus.mem_read_val : if_rd_q;
        d_rv_d    = gnt == GNT_D;
        d_rd_d    = gnt == GNT_D ? (bus.d_req_write ? '0 : bus.mem_read_val) : d_rd_q;
    end
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            state_q   <= RST_ST;
            clr_cnt_q <= '0;
            if_rv_q   <= 1'b0;
            if_rd_q   <= '0;
            d_rv_q    <= 1'b0;
            d_rd_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            if_rv_q   <= if_rv_d;
            if_rd_q   <= if_rd_d;
            d_rv_q    <= d_rv_d;
            d_rd_q    <= d_rd_d;
        end
endmodule

// File: tb/tb_shrimp_mem_arbiter.sv
// tb_shrimp_mem_arbiter: randomized and directed scoreboard bench for shrimp_mem_arbiter
module tb_shrimp_mem_arbiter;
    localparam int MAX_WAIT = 3;
    typedef struct {int cyc; int data;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int waited = 0;
    exp_t if_q[$];
    exp_t d_q[$];
    logic [15:0] mem [256];
    logic [15:0] shadow [256];
    shrimp_mem_arbiter_if bus ();
    shrimp_mem_arbiter #(.MAX_WAIT(MAX_WAIT), .CLEAR_ON_RESET(1'b1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus         (bus),
        .init_done_o (init_done)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign bus.mem_read_val = mem[bus.mem_addr];
    always @(posedge clk) if (bus.mem_write_enable) mem[bus.mem_addr] <= bus.mem_write_val;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    // Each response is due exactly one cycle after its grant was recorded.
    always @(negedge clk) begin
        if (if_q.size() > 0 && if_q[0].cyc == cyc - 1) begin
            chk("if_resp_valid", {31'b0, bus.if_resp_valid}, 1);
            chk("if_resp_data", {16'b0, bus.if_resp_data}, if_q[0].data);
            void'(if_q.pop_front());
        end else if (bus.if_resp_valid) chk("if_resp_unexpected", 1, 0);
        if (d_q.size() > 0 && d_q[0].cyc == cyc - 1) begin
            chk("d_resp_valid", {31'b0, bus.d_resp_valid}, 1);
            chk("d_resp_data", {16'b0, bus.d_resp_data}, d_q[0].data);
            void'(d_q.pop_front());
        end else if (bus.d_resp_valid) chk("d_resp_unexpected", 1, 0);
    end
    task automatic step(input logic iv, input logic [7:0] ia, input logic dv, input logic dw,
                        input logic [7:0] da, input logic [15:0] dd, output logic gi, output logic gd);
        bus.if_req_valid = iv;
        bus.if_req_addr  = ia;
        bus.d_req_valid  = dv;
        bus.d_req_write  = dw;
        bus.d_req_addr   = da;
        bus.d_req_wdata  = dd;
        @(negedge clk);
        gi = iv && (!dv || waited == MAX_WAIT);
        gd = dv && !gi;
        chk("if_req_ready", {31'b0, bus.if_req_ready}, {31'b0, gi});
        chk("d_req_ready", {31'b0, bus.d_req_ready}, {31'b0, gd});
        chk("mem_write_enable", {31'b0, bus.mem_write_enable}, {31'b0, gd && dw});
        chk("mem_addr", {24'b0, bus.mem_addr}, gi ? ia : gd ? da : 0);
        if (gd && dw) chk("mem_write_val", {16'b0, bus.mem_write_val}, dd);
        if (gi) if_q.push_back('{cyc, shadow[ia]});
        if (gd) begin
            d_q.push_back('{cyc, dw ? 0 : shadow[da]});
            if (dw) shadow[da] = dd;
        end
        waited = (iv && !gi) ? (waited < MAX_WAIT ? waited + 1 : MAX_WAIT) : 0;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        logic gi, gd;
        step(0, 0, 0, 0, 0, 0, gi, gd);
    endtask
    task automatic sweep();
        int bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (!(bus.mem_write_enable && bus.mem_addr == i[7:0] && !bus.if_req_ready &&
                  !bus.d_req_ready && !init_done)) bad++;
        end
        chk("sweep_bad_cycles", bad, 0);
        @(negedge clk);
        chk("init_done_after_sweep", {31'b0, init_done}, 1);
        for (int i = 0; i < 256; i++) shadow[i] = 16'h0;
        waited = 0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic gi, gd;
        logic [7:0] pat;
        logic ip, dp, dwr;
        logic [7:0] ia, da;
        logic [15:0] dd;
        for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
        bus.if_req_valid = 0; bus.if_req_addr = 0;
        bus.d_req_valid = 0; bus.d_req_write = 0; bus.d_req_addr = 0; bus.d_req_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", {31'b0, init_done}, 0);
        chk("rst_if_resp_valid", {31'b0, bus.if_resp_valid}, 0);
        chk("rst_d_resp_valid", {31'b0, bus.d_resp_valid}, 0);
        chk("rst_d_resp_data", {16'b0, bus.d_resp_data}, 0);
        rst_n = 1'b1;
        sweep();
        step(0, 0, 1, 0, 8'h40, 0, gi, gd);
        step(0, 0, 1, 1, 8'h12, 16'hBEEF, gi, gd);
        step(0, 0, 1, 0, 8'h12, 0, gi, gd);
        idle();
        step(1, 8'h00, 0, 0, 0, 0, gi, gd);
        step(1, 8'h02, 0, 0, 0, 0, gi, gd);
        step(1, 8'h04, 0, 0, 0, 0, gi, gd);
        idle();
        pat = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 8'h03, 1, 0, 8'h04, 0, gi, gd);
            pat[i] = gi;
        end
        chk("starve_pattern", {24'b0, pat}, 32'h88);
        idle();
        step(1, 8'h20, 1, 1, 8'h20, 16'h1234, gi, gd);
        chk("race_store_first", {31'b0, gd}, 1);
        step(1, 8'h20, 0, 0, 0, 0, gi, gd);
        idle();
        ip = 0; dp = 0; ia = 0; da = 0; dd = 0; dwr = 0;
        for (int n = 0; n < 400; n++) begin
            if (!ip && $urandom_range(0, 9) < 7) begin ip = 1; ia = 8'($urandom_range(0, 15)); end
            if (!dp && $urandom_range(0, 9) < 7) begin
                dp = 1; dwr = 1'($urandom_range(0, 1)); da = 8'($urandom_range(0, 15)); dd = 16'($urandom);
            end
            step(ip, ia, dp, dwr, da, dd, gi, gd);
            if (gi) ip = 0;
            if (gd) dp = 0;
        end
        idle();
        idle();
        bus.d_req_valid = 1; bus.d_req_write = 0; bus.d_req_addr = 8'h05;
        @(negedge clk);
        chk("midrst_grant", {31'b0, bus.d_req_ready}, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.d_req_valid = 0;
        @(negedge clk);
        chk("midrst_no_resp", {31'b0, bus.d_resp_valid}, 0);
        chk("midrst_init_done", {31'b0, init_done}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep();
        step(1, 8'h12, 0, 0, 0, 0, gi, gd);
        idle();
        idle();
        chk("queues_drained", if_q.size() + d_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
